// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready. Optional illegal-instruction trap under `MC_ILLEGAL_TRAP_EN`.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4, latch IR/OldPC
// DECODE   | read regfile, ALUOut <= OldPC + imm (branch/jump target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 to memory at ALUOut, wait for mem_ready
// EXECUTER | ALUOut <= rs1 op rs2
// EXECUTEI | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare rs1/rs2, PC <= ALUOut when equal
// JAL      | PC <= ALUOut, ALUOut <= OldPC + 4
// TRAP     | illegal instruction, parked until reset (trap build only)
module multicycle_control_unit #(
  parameter int WAIT_TIMEOUT = 0,
  parameter int TO_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]      state_q, state_d;
  logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            timeout_q, timeout_d;

  logic [1:0] alu_op;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic       in_wait, stall;
  logic       funct3_ok;

  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_op  = 2'b10;
`ifdef MC_ILLEGAL_TRAP_EN
        state_d = funct3_ok ? S_ALUWB : S_TRAP;
`else
        state_d = S_ALUWB;
`endif
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = Zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Unsupported funct3 falls back to add so the default build never stalls on it.
  always_comb begin
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

  // funct3_ok only steers the FSM in the trap build.
`ifndef MC_ILLEGAL_TRAP_EN
  logic unused_funct3_ok;
  assign unused_funct3_ok = funct3_ok;
`endif

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE);
  assign stall   = in_wait && !mem_ready;

  always_comb begin
    stall_cnt_d = '0;
    if (stall) stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
    timeout_d = timeout_q;
    if ((WAIT_TIMEOUT != 0) && (stall_cnt_d == TO_W'(WAIT_TIMEOUT))) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Write enables are forced low during reset so an abandoned instruction commits nothing.
  assign PCWrite     = pc_write_c  & ~reset;
  assign MemWrite    = mem_write_c & ~reset;
  assign IRWrite     = ir_write_c  & ~reset;
  assign RegWrite    = reg_write_c & ~reset;
  assign mem_timeout = timeout_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (WAIT_TIMEOUT=4); control outputs
// are packed into one vector and compared against hand-derived state signatures.
module tb_multicycle_control_unit;
  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_timeout, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [15:0] ctl;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_control_unit #(.WAIT_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .mem_timeout(mem_timeout),
    .illegal_instr(illegal_instr)
  );

  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic [1:0] imm,
                                     input logic rw);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
  endfunction

  function automatic logic [15:0] fetch_v(input logic [1:0] imm);
    return ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
  endfunction

  function automatic logic [15:0] decode_v(input logic [1:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
  endfunction

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input logic mr);
    op = o; funct3 = f3; funct7 = f7; Zero = z; mem_ready = mr;
  endtask

  // check the current cycle's outputs, then advance one clock
  task automatic step(input string tag, input logic [15:0] e);
    #1;
    chk(tag, {16'h0, ctl}, {16'h0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu);
    set_in(o, f3, f7, 0, 1);
    step({tag, "_fetch"}, fetch_v(2'b00));
    step({tag, "_decode"}, decode_v(2'b00));
    step({tag, "_exec"}, ev(0, 0, 0, 0, 2'b00, 2'b10, o[5] ? 2'b00 : 2'b01, alu, 2'b00, 0));
    step({tag, "_aluwb"}, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1));
  endtask

  initial begin
    reset = 1'b1;
    set_in(7'b0110011, 3'b000, 0, 0, 1);
    #1;
    chk("rst_we_0", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    @(posedge clk); #1;
    chk("rst_we_1", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    @(posedge clk); #1;
    chk("rst_flags", {30'h0, mem_timeout, illegal_instr}, 32'h0);
    reset = 1'b0;

    alu_instr("add", 7'b0110011, 3'b000, 0, 3'b000);
    alu_instr("sub", 7'b0110011, 3'b000, 1, 3'b001);
    alu_instr("addi_f7", 7'b0010011, 3'b000, 1, 3'b000);
    alu_instr("slt", 7'b0110011, 3'b010, 0, 3'b101);
    alu_instr("ori", 7'b0010011, 3'b110, 0, 3'b011);
    alu_instr("and", 7'b0110011, 3'b111, 0, 3'b010);
`ifndef MC_ILLEGAL_TRAP_EN
    alu_instr("xori_unk", 7'b0010011, 3'b100, 0, 3'b000);
`endif

    // lw with three stall cycles in MEMREAD
    set_in(7'b0000011, 3'b010, 0, 0, 1);
    step("lw_fetch", fetch_v(2'b00));
    step("lw_decode", decode_v(2'b00));
    step("lw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    mem_ready = 0;
    for (int i = 0; i < 3; i++) step("lw_memread_wait", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    mem_ready = 1;
    step("lw_memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    step("lw_memwb", ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1));
    chk("lw_no_timeout", {31'h0, mem_timeout}, 32'h0);

    // sw with one stall cycle in MEMWRITE
    set_in(7'b0100011, 3'b010, 0, 0, 1);
    step("sw_fetch", fetch_v(2'b01));
    step("sw_decode", decode_v(2'b01));
    step("sw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    mem_ready = 0;
    step("sw_memwrite_wait", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    mem_ready = 1;
    step("sw_memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));

    set_in(7'b1100011, 3'b000, 0, 1, 1);
    step("beq1_fetch", fetch_v(2'b10));
    step("beq1_decode", decode_v(2'b10));
    step("beq1_taken", ev(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    Zero = 0;
    step("beq0_fetch", fetch_v(2'b10));
    step("beq0_decode", decode_v(2'b10));
    step("beq0_nottaken", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));

    set_in(7'b1101111, 3'b000, 0, 0, 1);
    step("jal_fetch", fetch_v(2'b11));
    step("jal_decode", decode_v(2'b11));
    step("jal_jal", ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
    step("jal_aluwb", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1));

    // reset asserted in ALUWB: no register write, next cycle is FETCH
    set_in(7'b0110011, 3'b000, 0, 0, 1);
    step("rmid_fetch", fetch_v(2'b00));
    step("rmid_decode", decode_v(2'b00));
    step("rmid_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0));
    reset = 1;
    step("rmid_aluwb_rst", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    reset = 0;

    // stall timeout in FETCH
    mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), {31'h0, mem_timeout}, {31'h0, (i >= 4)});
      chk($sformatf("to_fetch_we%0d", i), {30'h0, PCWrite, IRWrite}, 32'h0);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    step("to_fetch", fetch_v(2'b00));
    step("to_decode", decode_v(2'b00));
    chk("to_sticky", {31'h0, mem_timeout}, 32'h1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("to_cleared", {31'h0, mem_timeout}, 32'h0);

    // unknown opcode
    set_in(7'b1111111, 3'b000, 0, 0, 1);
    step("ill_fetch", fetch_v(2'b00));
    step("ill_decode", decode_v(2'b00));
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill_trap_flag", {31'h0, illegal_instr}, 32'h1);
      step("ill_trap", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("ill_trap_cleared", {31'h0, illegal_instr}, 32'h0);
`else
    chk("ill_flag", {31'h0, illegal_instr}, 32'h0);
    step("ill_back_fetch", fetch_v(2'b00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
